// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC sequencer slice: default datapath widths,
// the MAC pipeline latency and the sequencer state encoding. Also provides
// a constant function used to check at elaboration time that the
// accumulator can never overflow for a full-length job.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_OUT_WIDTH  = 22;
    localparam int DEF_ADDR_WIDTH = 6;

    // Cycles from a read issue until the MAC accumulator output reflects it:
    // buffer read, multiplier register, accumulator register.
    localparam int MAC_PIPE_LAT = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // True when the largest possible sum, 2**addr_w products of two
    // all-ones operands, is representable in out_w bits.
    function automatic bit acc_fits(input int addr_w, input int in_w, input int out_w);
        longint unsigned max_op;
        longint unsigned worst;
        max_op = (64'd1 << in_w) - 64'd1;
        worst  = (64'd1 << addr_w) * max_op * max_op;
        return worst < (64'd1 << out_w);
    endfunction

endpackage

// File: rtl/mac_en_pipe.sv
// ---------------------------------------------------------------------------
// mac_en_pipe
// Two-stage delay line that turns the buffer read strobe into the MAC
// multiplier and accumulator load enables, so each enable lines up with the
// data sitting in front of the corresponding MAC register.
// Ports:
//   clk     - clock
//   rst_n   - synchronous active-low clear, flushes pending enables
//   rd_en   - buffer read strobe
//   mul_en  - rd_en delayed one cycle (multiplier register load)
//   ac_en   - rd_en delayed two cycles (accumulator load)
// ---------------------------------------------------------------------------
module mac_en_pipe (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_en,
    output logic mul_en,
    output logic ac_en
);

    // Shift the read strobe through both stages; a reset drops any enables
    // still in flight so an aborted job cannot touch the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_en <= 1'b0;
            ac_en  <= 1'b0;
        end else begin
            mul_en <= rd_en;
            ac_en  <= mul_en;
        end
    end

endmodule

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq
// Sequencer for one external MAC datapath. On start it clears the MAC,
// reads len operand pairs from the image/weight buffers (one per cycle),
// lets the MAC pipeline drain, captures the accumulated sum and offers it
// downstream over a valid/ready handshake.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   start, len                  - job request and product count (0..2**ADDR_WIDTH)
//   busy                        - high whenever a job is in progress
//   mem_rd_en, mem_addr         - shared read strobe/address to both buffers
//   img_data, weight_data       - buffer read data (one cycle after mem_rd_en)
//   img_in, weight_in           - operands to the MAC
//   mul_mem_en, ac_mem_en       - MAC multiplier / accumulator load enables
//   rst_mem                     - registered active-high clear to the MAC
//   mac_out                     - MAC accumulator value
//   result, result_valid,
//   result_ready                - captured sum and its handshake
// ---------------------------------------------------------------------------
module mac_seq
    import mac_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [IN_WIDTH-1:0]   img_data,
    input  logic [IN_WIDTH-1:0]   weight_data,
    output logic [IN_WIDTH-1:0]   img_in,
    output logic [IN_WIDTH-1:0]   weight_in,
    output logic                  mul_mem_en,
    output logic                  ac_mem_en,
    output logic                  rst_mem,
    input  logic [OUT_WIDTH-1:0]  mac_out,
    output logic [OUT_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int               CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_LEN   = CNT_W'(2 ** ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(MAC_PIPE_LAT - 1);

    // A full-length job of all-ones operands must not wrap the accumulator.
    if (!acc_fits(ADDR_WIDTH, IN_WIDTH, OUT_WIDTH)) begin : g_width_check
        $error("mac_seq: OUT_WIDTH too small for 2**ADDR_WIDTH max-value products");
    end

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic             issue_last;
    logic             drain_last;

    // cnt is shared: it walks the read addresses in ISSUE and then counts
    // the drain cycles, so it is back at zero on entry to each of them.
    assign issue_last = (cnt == len_q - CNT_W'(1));
    assign drain_last = (cnt == DRAIN_END);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero-length job skips ISSUE but still drains so
    // the result latency stays len+5 and the (cleared) MAC value is captured.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = (len_q != '0) ? ISSUE : DRAIN;
            ISSUE:   if (issue_last) next_state = DRAIN;
            DRAIN:   if (drain_last) next_state = DONE;
            DONE:    if (result_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy         = (state != IDLE);
        mem_rd_en    = (state == ISSUE);
        result_valid = (state == DONE);
        mem_addr     = '0;
        if (state == ISSUE) begin
            mem_addr = cnt[ADDR_WIDTH-1:0];
        end
    end

    // Job length latch, address/drain counter and result capture. The result
    // is sampled on the last drain cycle, when mac_out already includes the
    // final product, and is held untouched through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q  <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        len_q <= len;
                    end
                end
                ISSUE: begin
                    cnt <= issue_last ? '0 : cnt + CNT_W'(1);
                end
                DRAIN: begin
                    cnt <= drain_last ? '0 : cnt + CNT_W'(1);
                    if (drain_last) begin
                        result <= mac_out;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // The MAC uses rst_mem as an asynchronous clear, so it comes straight
    // from a flop. It is held high throughout sequencer reset and otherwise
    // pulses for exactly the CLEAR cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_mem <= 1'b1;
        end else begin
            rst_mem <= (next_state == CLEAR);
        end
    end

    mac_en_pipe u_en_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_en  (mem_rd_en),
        .mul_en (mul_mem_en),
        .ac_en  (ac_mem_en)
    );

    assign img_in    = img_data;
    assign weight_in = weight_data;

    len_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE && start) |-> (len <= MAX_LEN));

endmodule

// File: tb/tb_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_seq
// Bench for mac_seq: models the two operand buffers (1-cycle read latency)
// and the MAC itself (multiplier register + accumulator with async clear),
// keeps a scoreboard of expected sums and result cycles per launched job.
// ---------------------------------------------------------------------------
module tb_mac_seq;

    localparam int IW = 8;
    localparam int OW = 22;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          result_ready = 1'b0;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] img_data;
    logic [IW-1:0] weight_data;
    logic [IW-1:0] img_in;
    logic [IW-1:0] weight_in;
    logic          mul_mem_en;
    logic          ac_mem_en;
    logic          rst_mem;
    logic [OW-1:0] mac_out;
    logic [OW-1:0] result;
    logic          result_valid;

    logic [IW-1:0]   img_mem [64];
    logic [IW-1:0]   wt_mem  [64];
    logic [2*IW-1:0] mul_q;
    logic [OW-1:0]   acc;

    int cyc = 0;
    int rd_count = 0;
    int errors = 0;
    int checks = 0;

    logic [OW-1:0] sb_q [$];
    int            lat_q [$];

    always #5 clk = ~clk;

    // Cycle index and read-strobe count, both stepped at the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en === 1'b1) rd_count <= rd_count + 1;
    end

    // Operand buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            img_data    <= img_mem[mem_addr];
            weight_data <= wt_mem[mem_addr];
        end
    end

    // Reference MAC: multiplier register then accumulator, async clear.
    always @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            mul_q <= '0;
            acc   <= '0;
        end else begin
            if (mul_mem_en) mul_q <= img_in * weight_in;
            if (ac_mem_en)  acc   <= acc + OW'(mul_q);
        end
    end
    assign mac_out = acc;

    mac_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .img_data     (img_data),
        .weight_data  (weight_data),
        .img_in       (img_in),
        .weight_in    (weight_in),
        .mul_mem_en   (mul_mem_en),
        .ac_mem_en    (ac_mem_en),
        .rst_mem      (rst_mem),
        .mac_out      (mac_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // Push the expected sum and result cycle, then pulse start for one cycle.
    // Entered and left just after a falling edge; returns in cycle s+1.
    task automatic launch(input int n);
        longint sum;
        sum = 0;
        for (int i = 0; i < n; i++) sum += longint'(img_mem[i]) * longint'(wt_mem[i]);
        sb_q.push_back(OW'(sum));
        lat_q.push_back(cyc + n + 5);
        start = 1'b1;
        len   = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for result_valid; returns on the falling edge it is seen.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, mem_rd_en, mul_mem_en, ac_mem_en, result_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {busy, mem_rd_en, mul_mem_en, ac_mem_en, result_valid});
        end
        checks++;
        if (rst_mem !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_rst_mem: got %b expected 1", rst_mem);
        end
        checks++;
        if (result !== '0 || mem_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got result=%0d addr=%0d expected 0/0", result, mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rst_mem !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_rst_mem: got %b expected 0", rst_mem);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int rd0;
        logic [OW-1:0] exp;
        int exp_cyc;
        for (int i = 0; i < 4; i++) begin
            img_mem[i] = IW'(i + 1);
            wt_mem[i]  = IW'(i + 5);
        end
        rd0 = rd_count;
        launch(4);
        checks++;
        if (rst_mem !== 1'b1 || busy !== 1'b1 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_clear: got rst_mem=%b busy=%b rd=%b expected 1/1/0",
                     rst_mem, busy, mem_rd_en);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_rd_en !== 1'b1 || mem_addr !== AW'(k) || mul_mem_en !== (k >= 1)
                || ac_mem_en !== (k >= 2)) begin
                errors++;
                $display("[TB] FAIL basic_issue%0d: got rd=%b addr=%0d mul=%b ac=%b expected 1/%0d/%b/%b",
                         k, mem_rd_en, mem_addr, mul_mem_en, ac_mem_en, k, k >= 1, k >= 2);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_issue_end: got rd=%b expected 0", mem_rd_en);
        end
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc) begin
            errors++;
            $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", cyc, exp_cyc);
        end
        checks++;
        if (result !== exp || result !== OW'(70)) begin
            errors++;
            $display("[TB] FAIL basic_result: got %0d expected %0d", result, exp);
        end
        checks++;
        if (rd_count - rd0 !== 4) begin
            errors++;
            $display("[TB] FAIL basic_reads: got %0d expected 4", rd_count - rd0);
        end
        accept();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_handshake: got busy=%b valid=%b expected 0/0", busy, result_valid);
        end
    endtask

    task automatic test_max();
        bit ok;
        logic [OW-1:0] exp;
        int exp_cyc;
        for (int i = 0; i < 64; i++) begin
            img_mem[i] = 8'hFF;
            wt_mem[i]  = 8'hFF;
        end
        launch(64);
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc) begin
            errors++;
            $display("[TB] FAIL max_latency: got cycle %0d expected %0d", cyc, exp_cyc);
        end
        checks++;
        if (result !== exp || result !== OW'(4161600)) begin
            errors++;
            $display("[TB] FAIL max_result: got %0d expected %0d", result, exp);
        end
        accept();
    endtask

    task automatic test_zero();
        bit ok;
        int rd0;
        logic [OW-1:0] exp;
        int exp_cyc;
        rd0 = rd_count;
        launch(0);
        checks++;
        if (rst_mem !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_clear: got rst_mem=%b expected 1", rst_mem);
        end
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc) begin
            errors++;
            $display("[TB] FAIL zero_latency: got cycle %0d expected %0d", cyc, exp_cyc);
        end
        checks++;
        if (result !== exp || rd_count !== rd0) begin
            errors++;
            $display("[TB] FAIL zero_result: got result=%0d reads=%0d expected %0d/0",
                     result, rd_count - rd0, exp);
        end
        accept();
    endtask

    task automatic test_hold();
        bit ok;
        logic [OW-1:0] exp;
        int exp_cyc;
        img_mem[0] = 8'd2; img_mem[1] = 8'd3;
        wt_mem[0]  = 8'd4; wt_mem[1]  = 8'd5;
        launch(2);
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc || result !== exp) begin
            errors++;
            $display("[TB] FAIL hold_first: got cycle %0d result %0d expected %0d/%0d",
                     cyc, result, exp_cyc, exp);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len   = 7'd5;
            end
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (result !== exp || result_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_stable%0d: got result=%0d valid=%b busy=%b expected %0d/1/1",
                         i, result, result_valid, busy, exp);
            end
        end
        accept();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release: got busy=%b valid=%b expected 0/0", busy, result_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_start_ignored: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [OW-1:0] exp;
        int exp_cyc;
        for (int i = 0; i < 4; i++) begin
            img_mem[i] = 8'd9;
            wt_mem[i]  = 8'd9;
        end
        launch(4);
        repeat (3) @(negedge clk);
        checks++;
        if (mem_addr !== AW'(2) || mem_rd_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got addr=%0d rd=%b expected 2/1", mem_addr, mem_rd_en);
        end
        void'(sb_q.pop_back());
        void'(lat_q.pop_back());
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, mem_rd_en, mul_mem_en, ac_mem_en, result_valid} !== 5'b0
            || rst_mem !== 1'b1 || result !== '0 || mem_addr !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_state: got flags=%b rst_mem=%b result=%0d addr=%0d expected 00000/1/0/0",
                     {busy, mem_rd_en, mul_mem_en, ac_mem_en, result_valid}, rst_mem, result, mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        img_mem[0] = 8'd3; img_mem[1] = 8'd3;
        wt_mem[0]  = 8'd4; wt_mem[1]  = 8'd4;
        launch(2);
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc || result !== exp || result !== OW'(24)) begin
            errors++;
            $display("[TB] FAIL midrst_next: got cycle %0d result %0d expected %0d/%0d",
                     cyc, result, exp_cyc, exp);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [OW-1:0] exp;
        int exp_cyc;
        for (int i = 0; i < 3; i++) begin
            img_mem[i] = 8'd1;
            wt_mem[i]  = 8'd1;
        end
        launch(3);
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc || result !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_first: got cycle %0d result %0d expected %0d/%0d",
                     cyc, result, exp_cyc, exp);
        end
        img_mem[0] = 8'd2; img_mem[1] = 8'd2;
        wt_mem[0]  = 8'd5; wt_mem[1]  = 8'd5;
        accept();
        launch(2);
        wait_valid(ok);
        exp     = sb_q.pop_front();
        exp_cyc = lat_q.pop_front();
        checks++;
        if (!ok || cyc !== exp_cyc) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got cycle %0d expected %0d", cyc, exp_cyc);
        end
        checks++;
        if (result !== exp || result !== OW'(20)) begin
            errors++;
            $display("[TB] FAIL b2b_result: got %0d expected %0d", result, exp);
        end
        accept();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            img_mem[i] = '0;
            wt_mem[i]  = '0;
        end
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
